// File: rtl/booth_seq_multiplier_pkg.sv
// Shared width and Booth-digit definitions for the iterative radix-4 significand multiplier.
package booth_seq_multiplier_pkg;

    localparam int SIG_WIDTH = 23;

    typedef enum logic [2:0] {
        DIG_ZERO,
        DIG_PB,
        DIG_P2B,
        DIG_N2B,
        DIG_NB
    } booth_digit_e;

    // Radix-4 triplet {a[2i+1], a[2i], a[2i-1]} to signed multiple of b.
    function automatic booth_digit_e booth_decode(input logic [2:0] trip);
        booth_digit_e d;
        case (trip)
            3'b001, 3'b010: d = DIG_PB;
            3'b011:         d = DIG_P2B;
            3'b100:         d = DIG_N2B;
            3'b101, 3'b110: d = DIG_NB;
            default:        d = DIG_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Start/result handshake bundle between operand unpacking, the multiplier and the add stage.
interface booth_seq_multiplier_if
    import booth_seq_multiplier_pkg::*;
#(
    parameter int W = SIG_WIDTH + 1
);
    logic           start;
    logic           start_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;

    modport master (
        output start, a, b, out_ready,
        input  start_ready, busy, out_valid, product
    );

    modport slave (
        input  start, a, b, out_ready,
        output start_ready, busy, out_valid, product
    );
endinterface

// File: rtl/booth_seq_multiplier_recoder.sv
// Modified-Booth digit selector: picks one of the precomputed +-b / +-2b multiples.
module modifiedBoothRecoder
    import booth_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = SIG_WIDTH + 3
) (
    input  logic [2:0]              i_sel,
    input  logic signed [WIDTH-1:0] i_pb,
    input  logic signed [WIDTH-1:0] i_nb,
    input  logic signed [WIDTH-1:0] i_p2b,
    input  logic signed [WIDTH-1:0] i_n2b,
    output logic signed [WIDTH-1:0] o_pp
);
    booth_digit_e w_dig;

    always_comb begin
        w_dig = booth_decode(i_sel);
        o_pp  = '0;
        case (w_dig)
            DIG_PB:  o_pp = i_pb;
            DIG_NB:  o_pp = i_nb;
            DIG_P2B: o_pp = i_p2b;
            DIG_N2B: o_pp = i_n2b;
            default: o_pp = '0;
        endcase
    end
endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one digit per cycle through a shared recoder and adder.
module booth_seq_multiplier
    import booth_seq_multiplier_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    booth_seq_multiplier_if.slave  bus
);
    localparam int W    = SIG_WIDTH + 1;
    localparam int NDIG = W / 2 + 1;
    localparam int AW   = 2 * W + 2;
    localparam int SRW  = 2 * NDIG + 1;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e               r_state;
    logic [SRW-1:0]       r_mplr;
    logic signed [W+1:0]  r_pb;
    logic signed [W+1:0]  r_nb;
    logic signed [W+1:0]  r_p2b;
    logic signed [W+1:0]  r_n2b;
    logic signed [AW-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*W-1:0]       r_product;
    logic                 r_start_ready;
    logic                 r_busy;
    logic                 r_out_valid;

    logic signed [W+1:0]  w_b_ext;
    logic signed [W+1:0]  w_b2_ext;
    logic signed [W+1:0]  w_pp;
    logic signed [AW-1:0] w_pp_ext;
    logic signed [AW-1:0] w_addend;
    logic signed [AW-1:0] w_acc_next;
    logic                 w_last;

    assign w_b_ext  = {2'b00, bus.b};
    assign w_b2_ext = {1'b0, bus.b, 1'b0};

    // Bit 0 of the multiplier shift register is the implicit a[-1]; the low triplet is the current digit.
    modifiedBoothRecoder #(
        .WIDTH (W + 2)
    ) u_recoder (
        .i_sel (r_mplr[2:0]),
        .i_pb  (r_pb),
        .i_nb  (r_nb),
        .i_p2b (r_p2b),
        .i_n2b (r_n2b),
        .o_pp  (w_pp)
    );

    assign w_pp_ext   = {{(AW-W-2){w_pp[W+1]}}, w_pp};
    assign w_addend   = w_pp_ext <<< {r_cnt, 1'b0};
    assign w_acc_next = r_acc + w_addend;
    assign w_last     = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_product     <= '0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mplr        <= {{(SRW-W-1){1'b0}}, bus.a, 1'b0};
                        r_pb          <= w_b_ext;
                        r_nb          <= -w_b_ext;
                        r_p2b         <= w_b2_ext;
                        r_n2b         <= -w_b2_ext;
                        r_acc         <= '0;
                        r_cnt         <= '0;
                        r_state       <= S_BUSY;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_acc  <= w_acc_next;
                    r_mplr <= r_mplr >> 2;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product   <= w_acc_next[2*W-1:0];
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state       <= S_IDLE;
                        r_out_valid   <= 1'b0;
                        r_start_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_start_ready <= 1'b1;
                    r_busy        <= 1'b0;
                    r_out_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.busy        = r_busy;
    assign bus.out_valid   = r_out_valid;
    assign bus.product     = r_product;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed-vector and corner-sequence bench for booth_seq_multiplier.
module tb_booth_seq_multiplier;
    import booth_seq_multiplier_pkg::*;

    localparam int W    = SIG_WIDTH + 1;
    localparam int NDIG = W / 2 + 1;

    logic clk;
    logic reset;

    booth_seq_multiplier_if #(.W(W)) bus ();

    booth_seq_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs [10];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with start_ready=1; returns at the negedge of cycle 1.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat, output int nbusy, output int nready);
        lat    = lat0;
        nbusy  = 0;
        nready = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.busy) nbusy++;
            if (bus.start_ready) nready++;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [63:0] acc_top();
        return 64'(dut.r_acc[2*W+1:2*W]);
    endfunction

    initial begin
        int lat, nbusy, nready, bad;
        logic [W-1:0]   ra, rb;
        logic [63:0]    rexp;

        vecs[0] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
        vecs[1] = '{24'h800000, 24'h800000, 48'h400000000000};
        vecs[2] = '{24'hC00000, 24'hA00000, 48'h780000000000};
        vecs[3] = '{24'h000000, 24'hABCDEF, 48'h000000000000};
        vecs[4] = '{24'hAAAAAA, 24'h123457, 48'h0C22E49E87C6};
        vecs[5] = '{24'h000003, 24'h000005, 48'h00000000000F};
        vecs[6] = '{24'h000001, 24'h000001, 48'h000000000001};
        vecs[7] = '{24'hFFFFFF, 24'h000001, 48'h000000FFFFFF};
        vecs[8] = '{24'hABCDEF, 24'h000000, 48'h000000000000};
        vecs[9] = '{24'h800001, 24'h000002, 48'h000001000002};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            check("reset_idle", {bus.start_ready, bus.busy, bus.out_valid, 13'd0, bus.product},
                  {1'b1, 1'b0, 1'b0, 13'd0, 48'd0});
            @(negedge clk);
        end

        // Back-to-back at minimum issue interval, out_ready held high.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_done(1, lat, nbusy, nready);
            check("latency", 64'(lat), 64'(NDIG + 1));
            check("busy_cycles", 64'(nbusy), 64'(NDIG));
            check("ready_low_busy", 64'(nready), 64'd0);
            check("product", 64'(bus.product), 64'(vecs[i].exp));
            check("acc_top", acc_top(), 64'd0);
            @(negedge clk);
            check("done_to_idle", {62'd0, bus.out_valid, bus.start_ready}, 64'b01);
        end

        // Backpressure with stray starts during BUSY and DONE.
        bus.out_ready = 1'b0;
        issue(24'hAAAAAA, 24'h123457);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 24'hFFFFFF;
        bus.b     = 24'hFFFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(5, lat, nbusy, nready);
        check("hold_latency", 64'(lat), 64'(NDIG + 1));
        check("hold_product", 64'(bus.product), 64'h0C22E49E87C6);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            bus.start = (k % 3 == 0);
            @(negedge clk);
            if (!bus.out_valid || bus.start_ready || bus.product !== 48'h0C22E49E87C6) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("hold_release", {62'd0, bus.out_valid, bus.start_ready}, 64'b01);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.busy || bus.out_valid) bad++;
            @(negedge clk);
        end
        check("no_queued_start", 64'(bad), 64'd0);

        // Reset in the middle of an operation.
        issue(24'hFFFFFF, 24'hFFFFFF);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_state", {bus.start_ready, bus.busy, bus.out_valid, 13'd0, bus.product},
              {1'b1, 1'b0, 1'b0, 13'd0, 48'd0});
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid || bus.busy) bad++;
            @(negedge clk);
        end
        check("abort_no_valid", 64'(bad), 64'd0);
        issue(24'h000003, 24'h000005);
        wait_done(1, lat, nbusy, nready);
        check("after_abort_lat", 64'(lat), 64'(NDIG + 1));
        check("after_abort_prod", 64'(bus.product), 64'h00000000000F);
        @(negedge clk);

        // Random operand pairs against a behavioural product.
        for (int n = 0; n < 1500; n++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rexp = 64'(ra) * 64'(rb);
            issue(ra, rb);
            wait_done(1, lat, nbusy, nready);
            check("rand_product", 64'(bus.product), rexp);
            check("rand_acc_top", acc_top(), 64'd0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
